// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-sequence detector with a saturating match counter.
// Latency: z is registered and asserts on the clock edge that samples the final pattern bit.
// Backpressure: none. Every valid bit is consumed; cfg_load wins over w_valid and drops that bit.
//
// Ports:
//   clk, rst_n                   rising-edge clock, asynchronous active-low reset
//   w_valid, w                   serial bit and its sample strobe
//   cfg_load, cfg_pattern,       latch a new pattern, length (clamped to MAX_LEN)
//   cfg_len, cfg_overlap         and overlap mode; restarts history fill
//   cnt_clr                      synchronous clear of match_cnt (a same-cycle match still counts)
//   z                            one-cycle match pulse
//   armed                        enough history collected to match the active length
//   match_cnt, cnt_sat           saturating match count and its all-ones flag
module seq_detector_prog #(
    parameter int                   MAX_LEN     = 8,
    parameter int                   CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = 8'h0F,
    parameter int                   RST_LEN     = 4,
    parameter bit                   RST_OVERLAP = 1'b1,
    localparam int                  LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               w_valid,
    input  logic               w,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    // Only MAX_LEN-1 past bits need storing: the window being compared is
    // always those bits plus the bit arriving this cycle.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    state_t             state_q, state_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    // Select the low len_q bits of the window for comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        match   = 1'b0;
        hist_n  = {hist_q, w};

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            ovl_d  = cfg_overlap;
            fill_d = '0;
        end else if (w_valid) begin
            hist_d = hist_n[MAX_LEN-2:0];
            fill_d = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
            match  = (len_q != '0) && (fill_d >= len_q) &&
                     (((hist_n ^ pat_q) & len_mask) == '0);
            // Non-overlapping mode: the next match must be built from fresh bits.
            if (match && !ovl_q) begin
                fill_d = '0;
            end
        end

        // Clear takes effect first, so a coincident match leaves the count at one.
        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        sat_d   = &cnt_d;
        z_d     = match;
        state_d = (fill_d >= len_d) ? ARMED : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RST_PATTERN;
            len_q   <= LEN_W'(RST_LEN);
            ovl_q   <= RST_OVERLAP;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            state_q <= state_d;
        end
    end

    assign z         = z_q;
    assign armed     = (state_q == ARMED);
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: directed scenarios followed by random traffic,
// each cycle's expected outputs come from a bit-queue reference model.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               w_valid;
    logic               w;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               z;
    logic               armed;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    seq_detector_prog #(
        .MAX_LEN    (MAX_LEN),
        .CNT_W      (CNT_W),
        .RST_PATTERN(8'h0F),
        .RST_LEN    (4),
        .RST_OVERLAP(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_valid    (w_valid),
        .w          (w),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .z          (z),
        .armed      (armed),
        .match_cnt  (match_cnt),
        .cnt_sat    (cnt_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic z;
        logic armed;
        int   cnt;
        logic sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the bits received since fill last restarted, newest at the back.
    bit                 bits[$];
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    int                 m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        m_pat = 8'h0F;
        m_len = 4;
        m_ovl = 1'b1;
        m_cnt = 0;
    endtask

    // Monitor: compare every posted expectation one step after the edge it describes.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("z", int'(z), int'(e.z));
            chk("armed", int'(armed), int'(e.armed));
            chk("match_cnt", int'(match_cnt), e.cnt);
            chk("cnt_sat", int'(cnt_sat), int'(e.sat));
        end
    end

    task automatic step(input logic wv, input logic wb, input logic ld,
                        input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o, input logic clr);
        exp_t e;
        bit   m;
        int   n;
        @(negedge clk);
        w_valid     = wv;
        w           = wb;
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cnt_clr     = clr;
        m = 1'b0;
        if (ld) begin
            m_pat = p;
            m_len = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
            m_ovl = o;
            bits.delete();
        end else if (wv) begin
            bits.push_back(wb);
            if (bits.size() > MAX_LEN) void'(bits.pop_front());
            n = bits.size();
            if (m_len != 0 && n >= m_len) begin
                m = 1'b1;
                // Oldest bit of the window must equal pattern bit [len-1].
                for (int i = 0; i < m_len; i++) begin
                    if (bits[n - m_len + i] != m_pat[m_len - 1 - i]) m = 1'b0;
                end
            end
            if (m && !m_ovl) bits.delete();
        end
        if (clr) m_cnt = m ? 1 : 0;
        else if (m && m_cnt < CNT_MAX) m_cnt++;
        e.z     = m;
        e.armed = (bits.size() >= m_len);
        e.cnt   = m_cnt;
        e.sat   = (m_cnt == CNT_MAX);
        sb.push_back(e);
    endtask

    task automatic bit_in(input logic wv, input logic wb);
        step(wv, wb, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        step(1'b1, 1'b1, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_z"}, int'(z), 0);
        chk({tag, "_armed"}, int'(armed), 0);
        chk({tag, "_cnt"}, int'(match_cnt), 0);
        chk({tag, "_sat"}, int'(cnt_sat), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        w_valid = 1'b0; w = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
        cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        reset_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Default 1111 overlapping: six ones give three matches.
        repeat (6) bit_in(1'b1, 1'b1);

        // Non-overlapping: eight ones give two matches.
        load(8'h0F, 4'd4, 1'b0);
        repeat (8) bit_in(1'b1, 1'b1);

        // 101 overlapping, then non-overlapping.
        load(8'h05, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) bit_in(1'b1, logic'((i + 1) % 2));
        load(8'h05, 4'd3, 1'b0);
        for (int i = 0; i < 5; i++) bit_in(1'b1, logic'((i + 1) % 2));

        // Gapped valid strobes with w toggling while invalid.
        load(8'h0F, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in(1'b1, 1'b1);
            bit_in(1'b0, logic'(i % 2));
        end

        // Zero length disables detection; over-length is clamped.
        load(8'hFF, 4'd0, 1'b1);
        repeat (10) bit_in(1'b1, 1'b1);
        load(8'hFF, 4'd12, 1'b1);
        repeat (10) bit_in(1'b1, 1'b1);

        // Saturation, then clear coincident with a match.
        load(8'h0F, 4'd4, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        repeat (23) bit_in(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

        // Reset in the middle of a partial sequence.
        load(8'h0F, 4'd4, 1'b1);
        repeat (3) bit_in(1'b1, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("midreset");
        model_reset();
        #1;
        rst_n = 1'b1;
        repeat (4) bit_in(1'b1, 1'b1);

        // Random traffic with occasional reconfiguration and clears.
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                load(MAX_LEN'($urandom), LEN_W'($urandom_range(0, 10)), logic'($urandom_range(0, 1)));
            end else begin
                step(logic'($urandom_range(0, 99) < 75), logic'($urandom_range(0, 1)),
                     1'b0, '0, '0, 1'b0, logic'(r >= 98));
            end
        end

        @(negedge clk);
        w_valid = 1'b0;
        cfg_load = 1'b0;
        cnt_clr = 1'b0;
        for (int t = 0; t < 5 && sb.size() != 0; t++) @(posedge clk);
        #2;
        if (sb.size() != 0) chk("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
